// File: rtl/tone_voice.sv
// Single square-wave voice: tick-driven phase plus attack/sustain/release envelope, signed samples on request.
// Optional build macro TONE_VOICE_PHASE_RESET_EN: note_on rising edge and retrigger force phase to 0.
module tone_voice #(
    parameter int SAMPLE_W     = 16,
    parameter int AMP_MAX      = 32767,
    parameter int ATTACK_STEP  = 1024,
    parameter int RELEASE_STEP = 512
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic                note_on,
    input  logic                sample_req,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic [1:0]          env_state,
    output logic                active
);

    localparam logic [SAMPLE_W-1:0] AMP_MAX_C  = SAMPLE_W'(AMP_MAX);
    localparam logic [SAMPLE_W-1:0] ATT_STEP_C = SAMPLE_W'(ATTACK_STEP);
    localparam logic [SAMPLE_W-1:0] REL_STEP_C = SAMPLE_W'(RELEASE_STEP);
    localparam logic [SAMPLE_W-1:0] ZERO_C     = SAMPLE_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_t;

    // Saturating envelope step helpers; the sum cannot wrap since AMP_MAX leaves headroom in SAMPLE_W bits.
    function automatic logic [SAMPLE_W-1:0] sat_add(input logic [SAMPLE_W-1:0] a);
        logic [SAMPLE_W-1:0] s;
        s = a + ATT_STEP_C;
        if (s > AMP_MAX_C) begin
            return AMP_MAX_C;
        end else begin
            return s;
        end
    endfunction

    function automatic logic [SAMPLE_W-1:0] sat_sub(input logic [SAMPLE_W-1:0] a);
        if (a >= REL_STEP_C) begin
            return a - REL_STEP_C;
        end else begin
            return ZERO_C;
        end
    endfunction

    env_t                state_r;
    env_t                next_state_s;
    logic [SAMPLE_W-1:0] amp_r;
    logic [SAMPLE_W-1:0] amp_next_s;
    logic [SAMPLE_W-1:0] amp_up_s;
    logic [SAMPLE_W-1:0] amp_dn_s;
    logic [SAMPLE_W-1:0] sample_s;
    logic [SAMPLE_W-1:0] sample_r;
    logic                sample_valid_r;
    logic                active_r;
    logic                phase_r;
    logic                phase_next_s;
    logic                retrigger_s;

    assign amp_up_s = sat_add(amp_r);
    assign amp_dn_s = sat_sub(amp_r);

    // Envelope next-state and amplitude update.
    always_comb begin
        next_state_s = state_r;
        amp_next_s   = amp_r;
        retrigger_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (note_on) begin
                    next_state_s = ST_ATTACK;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ATTACK, ST_SUSTAIN: begin
                if (!note_on) begin
                    // A key release coincident with a request already takes the release step.
                    if (sample_req) begin
                        amp_next_s = amp_dn_s;
                    end else begin
                        amp_next_s = amp_r;
                    end
                    if (amp_next_s == ZERO_C) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_RELEASE;
                    end
                end else if (state_r == ST_ATTACK && sample_req) begin
                    amp_next_s = amp_up_s;
                    if (amp_up_s == AMP_MAX_C) begin
                        next_state_s = ST_SUSTAIN;
                    end else begin
                        next_state_s = ST_ATTACK;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_RELEASE: begin
                if (note_on) begin
                    retrigger_s = 1'b1;
                    if (sample_req) begin
                        amp_next_s = amp_up_s;
                    end else begin
                        amp_next_s = amp_r;
                    end
                    if (amp_next_s == AMP_MAX_C) begin
                        next_state_s = ST_SUSTAIN;
                    end else begin
                        next_state_s = ST_ATTACK;
                    end
                end else if (sample_req) begin
                    amp_next_s = amp_dn_s;
                    if (amp_dn_s == ZERO_C) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_RELEASE;
                    end
                end else begin
                    next_state_s = ST_RELEASE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                amp_next_s   = ZERO_C;
            end
        endcase
    end

`ifdef TONE_VOICE_PHASE_RESET_EN
    logic note_on_q_r;

    // Key edge register for the phase-reset feature.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            note_on_q_r <= 1'b0;
        end else begin
            note_on_q_r <= note_on;
        end
    end

    // Phase update; a note start wins over a coincident tick.
    always_comb begin
        phase_next_s = phase_r;
        if ((note_on && !note_on_q_r) || retrigger_s) begin
            phase_next_s = 1'b0;
        end else if (tick) begin
            phase_next_s = ~phase_r;
        end else begin
            phase_next_s = phase_r;
        end
    end
`else
    // Phase update; free-running on ticks.
    always_comb begin
        phase_next_s = phase_r;
        if (tick) begin
            phase_next_s = ~phase_r;
        end else begin
            phase_next_s = phase_r;
        end
    end
`endif

    // Sample uses the pre-toggle phase and the post-update amplitude.
    always_comb begin
        sample_s = amp_next_s;
        if (phase_r) begin
            sample_s = amp_next_s;
        end else begin
            sample_s = ZERO_C - amp_next_s;
        end
    end

    // State, amplitude, phase and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            amp_r          <= ZERO_C;
            phase_r        <= 1'b0;
            sample_r       <= ZERO_C;
            sample_valid_r <= 1'b0;
            active_r       <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            amp_r          <= amp_next_s;
            phase_r        <= phase_next_s;
            sample_valid_r <= sample_req;
            active_r       <= (next_state_s != ST_IDLE);
            if (sample_req) begin
                sample_r <= sample_s;
            end else begin
                sample_r <= sample_r;
            end
        end
    end

    assign sample       = sample_r;
    assign sample_valid = sample_valid_r;
    assign env_state    = state_r;
    assign active       = active_r;

endmodule

// File: tb/tb_tone_voice.sv
// Directed self-checking bench for tone_voice with hand-computed sample values.
module tb_tone_voice;

    logic        clock;
    logic        reset;
    logic        tick;
    logic        note_on;
    logic        sample_req;
    logic [15:0] sample;
    logic        sample_valid;
    logic [1:0]  env_state;
    logic        active;

    int n_tests;
    int n_fail;

    tone_voice dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .note_on      (note_on),
        .sample_req   (sample_req),
        .sample       (sample),
        .sample_valid (sample_valid),
        .env_state    (env_state),
        .active       (active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] exp_v;
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        tick       = 1'b0;
        note_on    = 1'b0;
        sample_req = 1'b0;
        cyc();
        cyc();
        check_val("rst_sample", 32'(sample), 32'h0);
        check_val("rst_valid", 32'(sample_valid), 32'h0);
        check_val("rst_env", 32'(env_state), 32'h0);
        check_val("rst_active", 32'(active), 32'h0);
        reset = 1'b0;

        // idle: tick honoured, request yields zero sample
        tick = 1'b1; cyc(); tick = 1'b0;
        sample_req = 1'b1; cyc(); sample_req = 1'b0;
        check_val("idle_valid", 32'(sample_valid), 32'h1);
        check_val("idle_sample", 32'(sample), 32'h0);
        check_val("idle_env", 32'(env_state), 32'h0);
        check_val("idle_active", 32'(active), 32'h0);
        cyc();
        check_val("idle_valid_drop", 32'(sample_valid), 32'h0);
        tick = 1'b1; cyc(); tick = 1'b0;

        // attack, back-to-back requests at phase 1
        note_on = 1'b1; cyc();
        check_val("att_env", 32'(env_state), 32'h1);
        check_val("att_active", 32'(active), 32'h1);
        tick = 1'b1; cyc(); tick = 1'b0;
        sample_req = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            cyc();
            exp_v = (k < 32) ? 32'(1024 * k) : 32'd32767;
            check_val("att_valid", 32'(sample_valid), 32'h1);
            check_val("att_sample", 32'(sample), exp_v);
        end
        sample_req = 1'b0;
        check_val("sus_env", 32'(env_state), 32'h2);
        cyc();
        check_val("sus_valid_drop", 32'(sample_valid), 32'h0);
        check_val("sus_hold", 32'(sample), 32'd32767);

        // sustain with phase 0
        tick = 1'b1; cyc(); tick = 1'b0;
        sample_req = 1'b1; cyc(); sample_req = 1'b0;
        check_val("sus_neg", 32'(sample), 32'h8001);

        // release, first step coincides with key drop
        tick = 1'b1; cyc(); tick = 1'b0;
        note_on = 1'b0;
        sample_req = 1'b1;
        for (int n = 1; n <= 64; n++) begin
            cyc();
            exp_v = (n < 64) ? 32'(32767 - 512 * n) : 32'd0;
            check_val("rel_sample", 32'(sample), exp_v);
            if (n == 1) check_val("rel_env_first", 32'(env_state), 32'h3);
            if (n == 63) check_val("rel_env_63", 32'(env_state), 32'h3);
        end
        sample_req = 1'b0;
        check_val("rel_env_idle", 32'(env_state), 32'h0);
        check_val("rel_active", 32'(active), 32'h0);

        // note start with coincident tick leaves phase 0 in either build
        note_on = 1'b1; tick = 1'b1; cyc(); tick = 1'b0;
        check_val("att2_env", 32'(env_state), 32'h1);
        tick = 1'b1; cyc(); tick = 1'b0;
        sample_req = 1'b1;
        repeat (32) cyc();
        sample_req = 1'b0;
        check_val("att2_sample", 32'(sample), 32'd32767);
        check_val("att2_env_sus", 32'(env_state), 32'h2);
        tick = 1'b1; sample_req = 1'b1; cyc(); tick = 1'b0; sample_req = 1'b0;
        check_val("coinc_sample", 32'(sample), 32'd32767);
        sample_req = 1'b1; cyc(); sample_req = 1'b0;
        check_val("coinc_after", 32'(sample), 32'h8001);

        // reset mid-attack
        note_on = 1'b0;
        reset = 1'b1; cyc(); reset = 1'b0;
        note_on = 1'b1; cyc();
        sample_req = 1'b1;
        repeat (5) cyc();
        sample_req = 1'b0;
        check_val("mid_sample", 32'(sample), 32'h0000EC00);
        check_val("mid_valid", 32'(sample_valid), 32'h1);
        #2 reset = 1'b1;
        #1;
        check_val("mid_rst_sample", 32'(sample), 32'h0);
        check_val("mid_rst_valid", 32'(sample_valid), 32'h0);
        check_val("mid_rst_env", 32'(env_state), 32'h0);
        check_val("mid_rst_active", 32'(active), 32'h0);
        cyc();
        reset = 1'b0;
        sample_req = 1'b1; cyc(); sample_req = 1'b0;
        check_val("post_rst_first", 32'(sample), 32'h0);
        check_val("post_rst_valid", 32'(sample_valid), 32'h1);
        sample_req = 1'b1; cyc(); sample_req = 1'b0;
        check_val("post_rst_att", 32'(sample), 32'h0000FC00);
        check_val("post_rst_env", 32'(env_state), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
